// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// calc_pkg : shared ALU op encodings, operand byte indices, loader states
// Rev 1.0
// ============================================================================
package calc_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7,
        OP_CMP = 4'd8,
        OP_NOP = 4'd15
    } alu_op_t;

    localparam logic [1:0] IDX_AL = 2'd0;
    localparam logic [1:0] IDX_AH = 2'd1;
    localparam logic [1:0] IDX_BL = 2'd2;
    localparam logic [1:0] IDX_BH = 2'd3;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/calc_byte_timeout.sv
`default_nettype none
// ============================================================================
// calc_byte_timeout : inter-byte idle counter with a one-cycle expiry pulse
// Rev 1.0
// ============================================================================
module calc_byte_timeout #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Expiry fires on the TIMEOUT-th consecutive idle cycle.
    assign expire = ena && run && !clear && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ena) begin
            if (clear || !run || expire) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_operand_loader.sv
`default_nettype none
// ============================================================================
// calc_operand_loader : byte stream -> {op_sel, op_a, op_b} with valid/ready
// Rev 1.0
// ============================================================================
module calc_operand_loader
    import calc_pkg::*;
#(
    parameter int AUTO_MODE = 1,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic [3:0]  op_in,
    input  logic        frame_clr,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic [3:0]  op_sel,
    output logic        opnd_valid,
    input  logic        opnd_ready,
    output logic [1:0]  byte_idx,
    output logic        overrun,
    output logic        frame_err
);

    loader_state_t state;
    logic          take;
    logic          to_expire;

    assign take = (AUTO_MODE != 0) ? 1'b1 : byte_valid;

    generate
        if (AUTO_MODE == 0 && TIMEOUT > 0) begin : g_timeout
            calc_byte_timeout #(
                .TIMEOUT (TIMEOUT),
                .TO_W    (TO_W)
            ) u_timeout (
                .clk    (clk),
                .rst_n  (rst_n),
                .ena    (ena),
                .clear  (frame_clr),
                .run    ((state == ST_COLLECT) && (byte_idx != IDX_AL) && !take),
                .expire (to_expire)
            );
        end else begin : g_no_timeout
            assign to_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_sel     <= '0;
            opnd_valid <= 1'b0;
            byte_idx   <= IDX_AL;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            state      <= ST_COLLECT;
        end else if (!ena) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (frame_clr) begin
                byte_idx   <= IDX_AL;
                opnd_valid <= 1'b0;
                overrun    <= 1'b0;
                state      <= ST_COLLECT;
                frame_err  <= (byte_idx != IDX_AL);
            end else begin
                case (state)
                    ST_COLLECT: begin
                        if (take) begin
                            case (byte_idx)
                                IDX_AL: op_a[7:0]  <= byte_in;
                                IDX_AH: op_a[15:8] <= byte_in;
                                IDX_BL: op_b[7:0]  <= byte_in;
                                default: begin
                                    op_b[15:8] <= byte_in;
                                    op_sel     <= op_in;
                                    opnd_valid <= 1'b1;
                                    state      <= ST_HOLD;
                                end
                            endcase
                            // IDX_BH + 1 wraps to IDX_AL for the next frame.
                            byte_idx <= byte_idx + 2'd1;
                        end else if (to_expire) begin
                            byte_idx  <= IDX_AL;
                            frame_err <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (opnd_ready) begin
                            opnd_valid <= 1'b0;
                            state      <= ST_COLLECT;
                            if (take) begin
                                op_a[7:0] <= byte_in;
                                byte_idx  <= IDX_AH;
                            end
                        end else if (take) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= ST_COLLECT;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_calc_operand_loader : randomized scoreboard bench, auto and strobed modes
// Rev 1.0
// ============================================================================
module tb_calc_operand_loader;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_a = 1'b0, ena_m = 1'b0;
    logic       byte_valid = 1'b0, frame_clr = 1'b0, opnd_ready = 1'b0;
    logic [7:0] byte_in = '0;
    logic [3:0] op_in = '0;

    logic [15:0] a_op_a, a_op_b, m_op_a, m_op_b;
    logic [3:0]  a_sel, m_sel;
    logic [1:0]  a_idx, m_idx;
    logic        a_valid, m_valid, a_ovr, m_ovr, a_ferr, m_ferr;

    calc_operand_loader #(.AUTO_MODE(1), .TIMEOUT(255), .TO_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .byte_in(byte_in),
        .byte_valid(byte_valid), .op_in(op_in), .frame_clr(frame_clr),
        .op_a(a_op_a), .op_b(a_op_b), .op_sel(a_sel), .opnd_valid(a_valid),
        .opnd_ready(opnd_ready), .byte_idx(a_idx), .overrun(a_ovr), .frame_err(a_ferr)
    );

    calc_operand_loader #(.AUTO_MODE(0), .TIMEOUT(TO), .TO_W(3)) dut_m (
        .clk(clk), .rst_n(rst_n), .ena(ena_m), .byte_in(byte_in),
        .byte_valid(byte_valid), .op_in(op_in), .frame_clr(frame_clr),
        .op_a(m_op_a), .op_b(m_op_b), .op_sel(m_sel), .opnd_valid(m_valid),
        .opnd_ready(opnd_ready), .byte_idx(m_idx), .overrun(m_ovr), .frame_err(m_ferr)
    );

    always #5 clk = ~clk;

    // sel = 0 observes the free-running instance, 1 the strobed one
    bit          sel = 1'b0;
    logic [15:0] s_a, s_b;
    logic [3:0]  s_sel;
    logic [1:0]  s_idx;
    logic        s_valid, s_ovr, s_ferr;
    assign s_a     = sel ? m_op_a  : a_op_a;
    assign s_b     = sel ? m_op_b  : a_op_b;
    assign s_sel   = sel ? m_sel   : a_sel;
    assign s_idx   = sel ? m_idx   : a_idx;
    assign s_valid = sel ? m_valid : a_valid;
    assign s_ovr   = sel ? m_ovr   : a_ovr;
    assign s_ferr  = sel ? m_ferr  : a_ferr;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes gathered per frame, completed frames queued
    logic [35:0] q[$];
    logic [7:0]  fb[4];
    int          mdl_cnt = 0, mdl_idle = 0, cap_k = -1;
    bit          mdl_hold = 0, mdl_ovr = 0, mdl_ferr = 0;

    task automatic model_reset();
        mdl_cnt = 0; mdl_idle = 0; mdl_hold = 0; mdl_ovr = 0; mdl_ferr = 0;
        q.delete();
    endtask

    task automatic cyc(input bit en, input bit bv, input logic [7:0] b,
                       input logic [3:0] op, input bit rdy, input bit clr);
        bit taken;
        logic [31:0] both;
        ena_a = en && !sel; ena_m = en && sel;
        byte_valid = bv; byte_in = b; op_in = op; opnd_ready = rdy; frame_clr = clr;
        @(posedge clk);
        mdl_ferr = 0; cap_k = -1;
        if (en) begin
            taken = sel ? bv : 1'b1;
            if (clr) begin
                mdl_ferr = (mdl_cnt != 0);
                mdl_cnt = 0; mdl_hold = 0; mdl_ovr = 0; mdl_idle = 0;
            end else if (mdl_hold) begin
                mdl_idle = 0;
                if (rdy) begin
                    mdl_hold = 0;
                    if (taken) begin fb[0] = b; cap_k = 0; mdl_cnt = 1; end
                end else if (taken) begin
                    mdl_ovr = 1;
                end
            end else if (taken) begin
                fb[mdl_cnt] = b; cap_k = mdl_cnt; mdl_idle = 0;
                if (mdl_cnt == 3) begin
                    q.push_back({op, fb[1], fb[0], fb[3], fb[2]});
                    mdl_cnt = 0; mdl_hold = 1;
                end else begin
                    mdl_cnt++;
                end
            end else if (sel && mdl_cnt != 0) begin
                mdl_idle++;
                if (mdl_idle == TO) begin mdl_cnt = 0; mdl_ferr = 1; mdl_idle = 0; end
            end else begin
                mdl_idle = 0;
            end
        end
        @(negedge clk);
        chk("byte_idx",   36'(s_idx),   36'(mdl_cnt));
        chk("opnd_valid", 36'(s_valid), 36'(mdl_hold));
        chk("overrun",    36'(s_ovr),   36'(mdl_ovr));
        chk("frame_err",  36'(s_ferr),  36'(mdl_ferr));
        if (cap_k >= 0) begin
            both = {s_b, s_a};
            chk("captured_byte", 36'(8'(both >> (8 * cap_k))), 36'(fb[cap_k]));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, {a_sel, a_op_a, a_op_b}, 36'd0);
        chk({tag, "_a_flags"}, 36'({a_valid, a_idx, a_ovr, a_ferr}), 36'd0);
        chk({tag, "_m"}, {m_sel, m_op_a, m_op_b}, 36'd0);
        chk({tag, "_m_flags"}, 36'({m_valid, m_idx, m_ovr, m_ferr}), 36'd0);
    endtask

    // Monitor: pops the expected frame whenever operands are presented
    logic        prev_v = 1'b0;
    logic [35:0] held = '0;
    always @(negedge clk) begin
        if (s_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected actual=%h expected=none", {s_sel, s_a, s_b});
            end else begin
                chk("sb_frame", {s_sel, s_a, s_b}, q.pop_front());
            end
            held = {s_sel, s_a, s_b};
        end else if (s_valid) begin
            chk("hold_stable", {s_sel, s_a, s_b}, held);
        end
        prev_v = s_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bs[4];
        #20;
        chk_all_zero("reset");
        #7 rst_n = 1'b1;
        @(negedge clk);

        // Free-running stream, ALU stalled
        bs = '{8'h00, 8'h40, 8'h00, 8'h80};
        foreach (bs[k]) cyc(1, 0, bs[k], 4'd12, 0, 0);
        chk("tp_frame", {s_sel, s_a, s_b}, {4'd12, 16'h4000, 16'h8000});
        cyc(1, 0, 8'h33, 4'd3, 0, 0);
        chk("tp_ovr_hold", {4'd0, s_ovr, 15'd0, s_a}, {4'd0, 1'b1, 15'd0, 16'h4000});
        cyc(1, 0, 8'h11, 4'd3, 1, 0);
        chk("tp_hs_byte", 36'({s_valid, s_idx, s_ovr, s_a[7:0]}), 36'({1'b0, 2'd1, 1'b1, 8'h11}));

        for (int i = 0; i < 300; i++)
            cyc(($urandom % 8) != 0, 0, 8'($urandom), 4'($urandom),
                ($urandom % 4) == 0, ($urandom % 30) == 0);

        // Asynchronous reset while presenting operands
        cyc(1, 0, 8'h00, 4'd0, 0, 1);
        foreach (bs[k]) cyc(1, 0, 8'($urandom | 1), 4'd9, 0, 0);
        chk("pre_rst_valid", 36'(a_valid), 36'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Strobed mode: bytes with gaps shorter than the timeout
        sel = 1'b1;
        bs = '{8'h34, 8'h12, 8'h78, 8'h56};
        foreach (bs[k]) begin
            cyc(1, 1, bs[k], 4'd5, 0, 0);
            for (int g = 0; g < (k % 3) && k < 3; g++) cyc(1, 0, 8'hFF, 4'd5, 0, 0);
        end
        chk("gap_frame", {s_sel, s_a, s_b}, {4'd5, 16'h1234, 16'h5678});
        cyc(1, 0, 8'h00, 4'd0, 1, 0);

        // Timeout after two bytes, then a fresh frame
        cyc(1, 1, 8'hA1, 4'd0, 0, 0);
        cyc(1, 1, 8'hA2, 4'd0, 0, 0);
        for (int i = 0; i < TO; i++) cyc(1, 0, 8'h00, 4'd0, 0, 0);
        chk("to_pulse", 36'({s_ferr, s_idx}), 36'({1'b1, 2'd0}));
        cyc(1, 0, 8'h00, 4'd0, 0, 0);
        chk("to_pulse_end", 36'(s_ferr), 36'd0);
        bs = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        foreach (bs[k]) cyc(1, 1, bs[k], 4'd7, 0, 0);
        chk("fresh_frame", {s_sel, s_a, s_b}, {4'd7, 16'hC2C1, 16'hC4C3});

        // Overrun, handshake with byte, then frame_clr at idx 2 with a byte
        cyc(1, 1, 8'hDD, 4'd7, 0, 0);
        cyc(1, 1, 8'h21, 4'd7, 1, 0);
        cyc(1, 1, 8'h22, 4'd7, 0, 0);
        chk("pre_clr", 36'({s_idx, s_ovr}), 36'({2'd2, 1'b1}));
        cyc(1, 1, 8'hEE, 4'd7, 0, 1);
        chk("clr_result", 36'({s_idx, s_ferr, s_ovr, s_a}), 36'({2'd0, 1'b1, 1'b0, 16'h2221}));

        for (int i = 0; i < 400; i++)
            cyc(($urandom % 8) != 0, ($urandom % 3) == 0, 8'($urandom), 4'($urandom),
                ($urandom % 4) == 0, ($urandom % 40) == 0);

        chk("sb_drained", 36'(q.size()), 36'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
